// File: rtl/ptmch_pkg.sv
// Shared types and constants for the pattern-match SPI capture path.
// No logic; imported by the capture front end and the compare stage.
package ptmch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPC  = 2'd1,
        ST_ARG  = 2'd2,
        ST_DATA = 2'd3
    } ptmch_state_e;

    // Flash opcodes recognised by the downstream compare stage
    localparam logic [7:0] PRGEXCT = 8'h10;
    localparam logic [7:0] RDSTAT  = 8'h0F;
    localparam logic [7:0] BLKERS  = 8'hD8;
    localparam logic [7:0] PDREAD  = 8'h13;

    localparam int DCNT_MAX_W = 16;

    typedef struct packed {
        logic [7:0]            opcode;
        logic [23:0]           addr;
        logic [1:0]            argcnt;
        logic [DCNT_MAX_W-1:0] datacnt;
    } cmd_rec_t;

endpackage

// File: rtl/ptmch_spi_capt_if.sv
// Sniffed SPI pins in, one-cycle command record and frame status out.
// Pure wiring; the record has no backpressure and must be taken when CMD_VALID pulses.
interface ptmch_spi_capt_if #(
    parameter int DCNT_W = 16
);
    logic              SPI_CS;
    logic              SPI_CLK;
    logic              SPI_MOSI;
    logic              CMD_VALID;
    logic [7:0]        CMD_OPCODE;
    logic [23:0]       CMD_ADDR;
    logic [1:0]        CMD_ARGCNT;
    logic [DCNT_W-1:0] CMD_DATACNT;
    logic              FRAME_ERR;
    logic              BUSY;

    modport master (
        input  SPI_CS, SPI_CLK, SPI_MOSI,
        output CMD_VALID, CMD_OPCODE, CMD_ADDR, CMD_ARGCNT, CMD_DATACNT,
        output FRAME_ERR, BUSY
    );

    modport slave (
        output SPI_CS, SPI_CLK, SPI_MOSI,
        input  CMD_VALID, CMD_OPCODE, CMD_ADDR, CMD_ARGCNT, CMD_DATACNT,
        input  FRAME_ERR, BUSY
    );
endinterface

// File: rtl/ptmch_sync_edge.sv
// STAGES-deep synchroniser plus one edge register; rise/fall valid STAGES cycles after the pin.
// No backpressure; o_lvl lags o_sync by one cycle.
module ptmch_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_d;

    // Reset to 0 so a pin already low at release never produces a fall edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_d    <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_d    <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_lvl  = r_d;
    assign o_rise =  r_sync[STAGES-1] & ~r_d;
    assign o_fall = ~r_sync[STAGES-1] &  r_d;

endmodule

// File: rtl/ptmch_spi_capt.sv
// Deserialises CS-framed SPI into opcode/args/data-count; record or FRAME_ERR SYNC_STAGES+1 cycles after CS rise.
// No backpressure: CMD_VALID and FRAME_ERR are single-cycle pulses, record held until the next CMD_VALID.
module ptmch_spi_capt
    import ptmch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ARG_BYTES   = 3,
    parameter int DCNT_W      = 16
) (
    input  logic              CLK160M,
    input  logic              RESET,
    ptmch_spi_capt_if.master  bus
);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] OPC  = ST_OPC;
    localparam logic [1:0] ARG  = ST_ARG;
    localparam logic [1:0] DATA = ST_DATA;

    localparam logic [1:0] ARG_LAST = 2'(ARG_BYTES - 1);

    logic w_cs_sync, w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_clk_sync, w_clk_lvl, w_clk_rise, w_clk_fall;
    logic w_mosi, w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    ptmch_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(CLK160M), .rst(RESET), .i_d(bus.SPI_CS),
        .o_sync(w_cs_sync), .o_lvl(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    ptmch_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(CLK160M), .rst(RESET), .i_d(bus.SPI_CLK),
        .o_sync(w_clk_sync), .o_lvl(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
    );

    // MOSI tapped at the same stage that produces the clock rise
    ptmch_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(CLK160M), .rst(RESET), .i_d(bus.SPI_MOSI),
        .o_sync(w_mosi), .o_lvl(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_cs_sync, w_clk_sync, w_clk_lvl, w_clk_fall,
                        w_mosi_lvl, w_mosi_rise, w_mosi_fall};

    logic [1:0]        r_state;
    logic [7:0]        r_shift;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_opc;
    logic [23:0]       r_addr;
    logic [1:0]        r_argcnt;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_armed;
    logic [7:0]        w_byte;

    assign w_byte = {r_shift[6:0], w_mosi};

    always_ff @(posedge CLK160M or posedge RESET) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_shift         <= '0;
            r_bitcnt        <= '0;
            r_opc           <= '0;
            r_addr          <= '0;
            r_argcnt        <= '0;
            r_dcnt          <= '0;
            bus.CMD_VALID   <= 1'b0;
            bus.CMD_OPCODE  <= '0;
            bus.CMD_ADDR    <= '0;
            bus.CMD_ARGCNT  <= '0;
            bus.CMD_DATACNT <= '0;
            bus.FRAME_ERR   <= 1'b0;
        end else begin
            bus.CMD_VALID <= 1'b0;
            bus.FRAME_ERR <= 1'b0;
            if (w_cs_rise) begin
                // CS release outranks any clock edge seen in the same cycle
                r_state  <= IDLE;
                r_bitcnt <= '0;
                if (r_bitcnt != 3'd0) begin
                    bus.FRAME_ERR <= 1'b1;
                end else if (r_state == ARG || r_state == DATA) begin
                    bus.CMD_VALID   <= 1'b1;
                    bus.CMD_OPCODE  <= r_opc;
                    bus.CMD_ADDR    <= r_addr;
                    bus.CMD_ARGCNT  <= r_argcnt;
                    bus.CMD_DATACNT <= r_dcnt;
                end
            end else if (w_cs_fall && r_state == IDLE) begin
                r_state  <= OPC;
                r_shift  <= '0;
                r_bitcnt <= '0;
                r_opc    <= '0;
                r_addr   <= '0;
                r_argcnt <= '0;
                r_dcnt   <= '0;
            end else if (w_clk_rise && r_state != IDLE) begin
                r_shift  <= w_byte;
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    case (r_state)
                        OPC: begin
                            r_opc   <= w_byte;
                            r_state <= ARG;
                        end
                        ARG: begin
                            r_addr   <= {r_addr[15:0], w_byte};
                            r_argcnt <= r_argcnt + 2'd1;
                            if (r_argcnt == ARG_LAST)
                                r_state <= DATA;
                        end
                        DATA: begin
                            if (r_dcnt != {DCNT_W{1'b1}})
                                r_dcnt <= r_dcnt + DCNT_W'(1);
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    // BUSY stays low until CS has been seen inactive once after reset
    always_ff @(posedge CLK160M or posedge RESET) begin
        if (RESET)
            r_armed <= 1'b0;
        else if (w_cs_lvl)
            r_armed <= 1'b1;
    end

    assign bus.BUSY = r_armed & ~w_cs_lvl;

endmodule
